// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl -- bit-serial adder/subtractor with a small control FSM.
//
// Purpose: one operation per start request. Operands are latched in IDLE and
// processed LSB first, one bit per clock, through a single full-adder stage
// and a carry flip-flop. The registered result appears together with a
// one-cycle done pulse.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset
//   start  in   begin an operation (honoured only in IDLE)
//   sub    in   0 = a + b + cin, 1 = a - b (cin ignored)
//   a, b   in   WIDTH-bit operands, sampled with start
//   cin    in   carry-in for add
//   sum    out  registered result of the last completed operation
//   cout   out  registered carry-out (sub: 1 = no borrow)
//   ovf    out  registered two's-complement overflow
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse when sum/cout/ovf update
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    // Counter only needs to reach WIDTH-1; WIDTH >= 2 keeps CW >= 1.
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Single full-adder stage fed by the operand LSBs and the carry FF.
    logic fa_x, fa_y, fa_s, fa_co;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        fa_x     = a_q[0];
        fa_y     = b_q[0];
        fa_s     = fa_x ^ fa_y ^ carry_q;
        fa_co    = (fa_x & fa_y) | (fa_x & carry_q) | (fa_y & carry_q);
        // Result bits enter at the MSB and walk down, so after WIDTH shifts
        // the first (LSB) result bit sits in bit 0.
        res_next = {fa_s, res_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    // Subtract is a + ~b + 1: invert b and preset the carry.
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                res_d   = res_next;
                carry_d = fa_co;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    sum_d   = res_next;
                    cout_d  = fa_co;
                    // On the last bit carry_q is the carry into the MSB.
                    ovf_d   = carry_q ^ fa_co;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);

endmodule
